// File: rtl/mmio_arb_pkg.sv
// rtl/mmio_arb_pkg.sv - shared types and limits for the MMIO bus arbiter
package mmio_arb_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        ACK
    } state_t;

    localparam int MAX_MST     = 8;
    localparam int RD_WAIT_MAX = 7;

endpackage

// File: rtl/mmio_bus_arbiter_rr_picker.sv
// rtl/mmio_bus_arbiter_rr_picker.sv - round-robin picker: first requester after ptr, one-hot and index
module rr_picker #(
    parameter int N    = 2,
    parameter int ID_W = 1
) (
    input  logic [N-1:0]    req,
    input  logic [ID_W-1:0] ptr,
    output logic [N-1:0]    gnt,
    output logic [ID_W-1:0] idx,
    output logic            any
);

    always_comb begin
        gnt = '0;
        idx = '0;
        any = 1'b0;
        // Search ptr+1 .. ptr+N so the last winner has the lowest priority
        for (int i = 1; i <= N; i++) begin
            if (!any && req[(int'(ptr) + i) % N]) begin
                any                     = 1'b1;
                gnt[(int'(ptr) + i) % N] = 1'b1;
                idx                     = ID_W'((int'(ptr) + i) % N);
            end
        end
    end

endmodule

// File: rtl/mmio_bus_arbiter.sv
// rtl/mmio_bus_arbiter.sv - round-robin single-beat arbiter sharing the FPro MMIO bus among N_MST masters
// Optional grant lock for atomic read-modify-write: MMIO_ARB_LOCK_EN
module mmio_bus_arbiter
    import mmio_arb_pkg::*;
#(
    parameter int N_MST   = 2,
    parameter int ADDR_W  = 21,
    parameter int DATA_W  = 32,
    parameter int RD_WAIT = 0,
    localparam int ID_W   = (N_MST > 1) ? $clog2(N_MST) : 1
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [N_MST-1:0]        m_req,
    input  logic [N_MST-1:0]        m_wr,
    input  logic [N_MST-1:0]        m_lock,
    input  logic [N_MST*ADDR_W-1:0] m_addr,
    input  logic [N_MST*DATA_W-1:0] m_wr_data,
    output logic [N_MST-1:0]        m_ack,
    output logic [DATA_W-1:0]       m_rd_data,
    output logic [ID_W-1:0]         gnt_id,
    output logic                    busy,
    output logic                    mmio_cs,
    output logic                    mmio_wr,
    output logic                    mmio_rd,
    output logic [ADDR_W-1:0]       mmio_addr,
    output logic [DATA_W-1:0]       mmio_wr_data,
    input  logic [DATA_W-1:0]       mmio_rd_data
);

    localparam logic [2:0] WAIT_LOAD = (RD_WAIT > 0) ? 3'(RD_WAIT - 1) : 3'd0;

    state_t            state, state_n;
    logic [ID_W-1:0]   ptr, pick_idx;
    logic [N_MST-1:0]  req_eff, pick_gnt;
    logic              pick_any, wr_q, sample_rd, sel_wr;
    logic [2:0]        wait_cnt;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_data;

`ifdef MMIO_ARB_LOCK_EN
    logic lock_q, lock_hold;

    // Lock only holds while the owner keeps m_lock high; dropping it re-arbitrates in the same IDLE cycle
    assign lock_hold = lock_q && m_lock[gnt_id];

    always_comb begin
        req_eff = '0;
        for (int i = 0; i < N_MST; i++)
            req_eff[i] = m_req[i] && (!lock_hold || gnt_id == ID_W'(i));
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            lock_q <= 1'b0;
        else if (state == ACK)
            lock_q <= m_lock[gnt_id];
        else if (state == IDLE)
            lock_q <= lock_hold;
    end
`else
    logic unused_lock;

    assign unused_lock = ^m_lock;
    assign req_eff     = m_req;
`endif

    rr_picker #(.N(N_MST), .ID_W(ID_W)) u_picker (
        .req (req_eff),
        .ptr (ptr),
        .gnt (pick_gnt),
        .idx (pick_idx),
        .any (pick_any)
    );

    always_comb begin
        sel_addr = '0;
        sel_data = '0;
        sel_wr   = 1'b0;
        for (int i = 0; i < N_MST; i++) begin
            if (pick_gnt[i]) begin
                sel_addr = sel_addr | m_addr[i*ADDR_W +: ADDR_W];
                sel_data = sel_data | m_wr_data[i*DATA_W +: DATA_W];
                sel_wr   = sel_wr | m_wr[i];
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            state <= IDLE;
        else
            state <= state_n;
    end

    always_comb begin
        state_n   = state;
        mmio_cs   = 1'b0;
        mmio_wr   = 1'b0;
        mmio_rd   = 1'b0;
        busy      = (state != IDLE);
        m_ack     = '0;
        sample_rd = 1'b0;
        case (state)
            IDLE:  if (pick_any) state_n = ISSUE;
            ISSUE: begin
                mmio_cs   = 1'b1;
                mmio_wr   = wr_q;
                mmio_rd   = !wr_q;
                sample_rd = !wr_q && (RD_WAIT == 0);
                state_n   = (RD_WAIT == 0) ? ACK : WAIT;
            end
            WAIT: begin
                if (wait_cnt == 3'd0) begin
                    sample_rd = !wr_q;
                    state_n   = ACK;
                end
            end
            ACK: begin
                for (int i = 0; i < N_MST; i++)
                    m_ack[i] = (gnt_id == ID_W'(i));
                state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ptr          <= ID_W'(N_MST - 1);
            gnt_id       <= '0;
            wr_q         <= 1'b0;
            wait_cnt     <= '0;
            mmio_addr    <= '0;
            mmio_wr_data <= '0;
            m_rd_data    <= '0;
        end else begin
            if (state == IDLE && pick_any) begin
                gnt_id       <= pick_idx;
                wr_q         <= sel_wr;
                mmio_addr    <= sel_addr;
                mmio_wr_data <= sel_data;
            end
            if (state == ISSUE)
                wait_cnt <= WAIT_LOAD;
            else if (state == WAIT)
                wait_cnt <= wait_cnt - 3'd1;
            if (sample_rd)
                m_rd_data <= mmio_rd_data;
            if (state == ACK)
                ptr <= gnt_id;
        end
    end

endmodule
